// File: rtl/io_input_handshake.sv
// ----------------------------------------------------------------------------
// io_input_handshake
//
// Sequencer between the CPU IO-read path and the board switch/confirm-button
// inputs. An IO read of the switch port stalls the CPU until the user presses
// the debounced confirm button. The 16 switch bits are then latched and the
// CPU is released with io_data qualified by a single-cycle io_valid pulse.
//
// Optional feature macro: IO_TIMEOUT_EN
//   When defined, a wait counter bounds the time spent waiting for a press.
//   After TIMEOUT_CYCLES wait cycles the read completes with io_data=16'h0000
//   and the sticky timeout_flag set. When undefined the block waits
//   indefinitely and timeout_flag is tied low.
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive stable cycles before the debounced level moves
//   TIMEOUT_CYCLES   press wait limit (only meaningful with IO_TIMEOUT_EN)
//
// Ports:
//   clk             in   1   CPU clock, all state changes on the rising edge
//   reset           in   1   synchronous, active-high
//   ior_req         in   1   CPU IO read of the switch port, held while pending
//   button_confirm  in   1   raw asynchronous confirm push-button
//   switch_in       in  16   raw asynchronous switch bits
//   cpu_stall       out  1   freezes PC / register-file write while high
//   io_data         out 16   latched switch value for the IO read mux
//   io_valid        out  1   one-cycle pulse, io_data answers the current read
//   waiting         out  1   high while waiting for release/press (LED)
//   timeout_flag    out  1   sticky until the next request (0 without timeout)
// ----------------------------------------------------------------------------
module io_input_handshake #(
    parameter int DEBOUNCE_CYCLES = 20,
    parameter int TIMEOUT_CYCLES  = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ior_req,
    input  logic        button_confirm,
    input  logic [15:0] switch_in,
    output logic        cpu_stall,
    output logic [15:0] io_data,
    output logic        io_valid,
    output logic        waiting,
    output logic        timeout_flag
);

    // Reject configurations where the counters would compare against a
    // negative or zero-length window.
    if (DEBOUNCE_CYCLES < 1 || TIMEOUT_CYCLES < 2) begin : g_bad_params
        $error("io_input_handshake: need DEBOUNCE_CYCLES >= 1 and TIMEOUT_CYCLES >= 2");
    end

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_RELEASE,
        WAIT_PRESS,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic             btn_meta;
    logic             sync_btn;
    logic [15:0]      sw_meta;
    logic [15:0]      sync_sw;

    logic [CNT_W-1:0] cnt;
    logic             db_level;
    logic             db_prev;
    logic             press_event;

    logic             latch_sw;

`ifdef IO_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

    logic [WAIT_W-1:0] wait_cnt;
    logic              timeout_hit;
    logic              timeout_fire;
    logic              start_wait;
    logic              flag_q;
`endif

    // Two-flop synchronisers for the asynchronous button and switches. The
    // switch bits are only consumed once the button has been stable for many
    // cycles, so per-bit skew between switch flops does not matter.
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_meta <= 1'b0;
            sync_btn <= 1'b0;
            sw_meta  <= '0;
            sync_sw  <= '0;
        end else begin
            btn_meta <= button_confirm;
            sync_btn <= btn_meta;
            sw_meta  <= switch_in;
            sync_sw  <= sw_meta;
        end
    end

    // Debouncer: the counter only runs while the synchronised button
    // disagrees with the debounced level, so any glitch back to the old level
    // restarts the stability window. db_prev is kept for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            db_level <= 1'b0;
            db_prev  <= 1'b0;
        end else begin
            db_prev <= db_level;
            if (sync_btn == db_level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                db_level <= sync_btn;
                cnt      <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // A press is the single cycle right after the debounced level rises.
    assign press_event = db_level & ~db_prev;

    // Handshake state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. In the wait states a withdrawn request always wins,
    // so an aborted read never latches data or pulses io_valid. In
    // WAIT_PRESS a genuine press beats a timeout landing in the same cycle.
    // Starting in WAIT_RELEASE when the button is already down stops a held
    // button from answering several reads in a row.
    always_comb begin
        state_next = state;
        latch_sw   = 1'b0;
`ifdef IO_TIMEOUT_EN
        start_wait   = 1'b0;
        timeout_fire = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (ior_req) begin
`ifdef IO_TIMEOUT_EN
                    start_wait = 1'b1;
`endif
                    state_next = db_level ? WAIT_RELEASE : WAIT_PRESS;
                end
            end
            WAIT_RELEASE: begin
                if (!ior_req) begin
                    state_next = IDLE;
`ifdef IO_TIMEOUT_EN
                end else if (timeout_hit) begin
                    state_next   = DONE;
                    timeout_fire = 1'b1;
`endif
                end else if (!db_level) begin
                    state_next = WAIT_PRESS;
                end
            end
            WAIT_PRESS: begin
                if (!ior_req) begin
                    state_next = IDLE;
                end else if (press_event) begin
                    state_next = DONE;
                    latch_sw   = 1'b1;
`ifdef IO_TIMEOUT_EN
                end else if (timeout_hit) begin
                    state_next   = DONE;
                    timeout_fire = 1'b1;
`endif
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Returned data: captured at the edge that enters DONE and then held
    // until the next completed read, regardless of later switch movement.
    always_ff @(posedge clk) begin
        if (reset) begin
            io_data <= '0;
        end else if (latch_sw) begin
            io_data <= sync_sw;
`ifdef IO_TIMEOUT_EN
        end else if (timeout_fire) begin
            io_data <= '0;
`endif
        end
    end

`ifdef IO_TIMEOUT_EN
    assign timeout_hit = (wait_cnt == WAIT_LAST);

    // Wait counter and sticky timeout flag. Both restart when a new request
    // leaves IDLE, so the flag describes the most recent read only.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
            flag_q   <= 1'b0;
        end else begin
            if (start_wait) begin
                wait_cnt <= '0;
                flag_q   <= 1'b0;
            end else if (waiting) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end
            if (timeout_fire) begin
                flag_q <= 1'b1;
            end
        end
    end

    assign timeout_flag = flag_q;
`else
    assign timeout_flag = 1'b0;
`endif

    // Stall is combinational on the request so the CPU freezes in the very
    // cycle the read appears; it drops only in DONE, where the CPU advances.
    assign cpu_stall = ior_req & (state != DONE);
    assign io_valid  = (state == DONE);
    assign waiting   = (state == WAIT_RELEASE) | (state == WAIT_PRESS);

endmodule

// File: tb/tb_io_input_handshake.sv
// ----------------------------------------------------------------------------
// tb_io_input_handshake
//
// Self-checking bench for io_input_handshake with DEBOUNCE_CYCLES=4 and
// TIMEOUT_CYCLES=50. A behavioural model tracks the handshake as a read
// "in progress / needs release / completed" with run-length button
// debouncing; every scenario compares the DUT against it each cycle and
// also checks the fixed cycle numbers and data values of the scenario.
// ----------------------------------------------------------------------------
module tb_io_input_handshake;

    localparam int DEB = 4;
    localparam int TMO = 50;

    logic        clk = 1'b0;
    logic        reset;
    logic        ior_req;
    logic        button_confirm;
    logic [15:0] switch_in;
    logic        cpu_stall;
    logic [15:0] io_data;
    logic        io_valid;
    logic        waiting;
    logic        timeout_flag;

    int n_checks = 0;
    int n_fail   = 0;

    // Model of the handshake as seen by the CPU.
    bit          m_active;
    bit          m_need_release;
    bit          m_done;
    bit          m_tflag;
    bit          m_level;
    bit          m_rose;
    bit          m_b1;
    bit          m_b2;
    int          m_run;
    int          m_wait;
    logic [15:0] m_data;
    logic [15:0] m_sw1;
    logic [15:0] m_sw2;

    // {cpu_stall, io_valid, waiting, timeout_flag, io_data}
    logic [19:0] exp_vec;
    logic [19:0] obs_vec;

    io_input_handshake #(
        .DEBOUNCE_CYCLES(DEB),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .ior_req       (ior_req),
        .button_confirm(button_confirm),
        .switch_in     (switch_in),
        .cpu_stall     (cpu_stall),
        .io_data       (io_data),
        .io_valid      (io_valid),
        .waiting       (waiting),
        .timeout_flag  (timeout_flag)
    );

    always #5 clk = ~clk;

    // Advance the model across one rising edge using this cycle's inputs.
    task automatic model_edge(input bit r, input bit req, input bit btn, input logic [15:0] sw);
        if (r) begin
            m_active = 0; m_need_release = 0; m_done = 0; m_tflag = 0;
            m_level = 0; m_rose = 0; m_b1 = 0; m_b2 = 0;
            m_run = 0; m_wait = 0; m_data = '0; m_sw1 = '0; m_sw2 = '0;
        end else begin
            if (m_done) begin
                m_done = 0;
            end else if (!m_active) begin
                if (req) begin
                    m_active = 1; m_need_release = m_level; m_wait = 0; m_tflag = 0;
                end
            end else if (!req) begin
                m_active = 0;
            end else if (!m_need_release && m_rose) begin
                m_data = m_sw2; m_done = 1; m_active = 0;
`ifdef IO_TIMEOUT_EN
            end else if (m_wait == TMO - 1) begin
                m_data = '0; m_tflag = 1; m_done = 1; m_active = 0;
`endif
            end else begin
                if (m_need_release && !m_level) m_need_release = 0;
                m_wait++;
            end
            // debounced level flips after DEB consecutive disagreeing cycles
            m_rose = 0;
            if (m_b2 == m_level) begin
                m_run = 0;
            end else begin
                m_run++;
                if (m_run == DEB) begin
                    m_level = m_b2; m_run = 0; m_rose = m_level;
                end
            end
            m_b2 = m_b1; m_b1 = btn;
            m_sw2 = m_sw1; m_sw1 = sw;
        end
    endtask

    // Drive one cycle, predict its outputs, sample the DUT at the falling edge.
    task automatic drive_cycle(input bit r, input bit req, input bit btn, input logic [15:0] sw);
        reset = r; ior_req = req; button_confirm = btn; switch_in = sw;
        exp_vec = {req & ~m_done, m_done, m_active, m_tflag, m_data};
        @(negedge clk);
        obs_vec = {cpu_stall, io_valid, waiting, timeout_flag, io_data};
        @(posedge clk);
        #1;
        model_edge(r, req, btn, sw);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) drive_cycle(0, 0, 0, switch_in);
    endtask

    task automatic test_reset();
        drive_cycle(1, 0, 0, 16'h0);
        drive_cycle(1, 0, 0, 16'h0);
        drive_cycle(0, 0, 0, 16'h1234);
        n_checks++;
        if (obs_vec !== 20'h00000) begin
            n_fail++; $display("[TB] FAIL reset_values: got %h expected %h", obs_vec, 20'h00000);
        end
        drive_cycle(0, 0, 0, 16'h1234);
        n_checks++;
        if (obs_vec !== exp_vec) begin
            n_fail++; $display("[TB] FAIL reset_model: got %h expected %h", obs_vec, exp_vec);
        end
    endtask

    task automatic test_basic();
        for (int c = 0; c < 14; c++) begin
            drive_cycle(0, c < 13, c >= 5, 16'hA5C3);
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_fail++; $display("[TB] FAIL basic_model c=%0d: got %h expected %h", c, obs_vec, exp_vec);
            end
            if (c <= 11) begin
                n_checks++;
                if (obs_vec[19:18] !== 2'b10) begin
                    n_fail++; $display("[TB] FAIL basic_stall c=%0d: stall,valid=%b expected 10", c, obs_vec[19:18]);
                end
            end
            if (c == 12) begin
                n_checks++;
                if (obs_vec[19:18] !== 2'b01 || obs_vec[15:0] !== 16'hA5C3) begin
                    n_fail++; $display("[TB] FAIL basic_done: stall,valid=%b data=%h expected 01 a5c3", obs_vec[19:18], obs_vec[15:0]);
                end
            end
        end
        idle_cycles(8);
    endtask

    task automatic test_bounce();
        logic [15:0] sw = 16'($urandom);
        int nvalid = 0;
        bit btn;
        for (int c = 0; c < 32; c++) begin
            btn = (c == 3) || (c >= 8 && c <= 9) || (c >= 14 && c <= 16) || (c >= 22 && c <= 27);
            drive_cycle(0, c <= 29, btn, sw);
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_fail++; $display("[TB] FAIL bounce_model c=%0d: got %h expected %h", c, obs_vec, exp_vec);
            end
            if (obs_vec[18]) begin
                nvalid++;
                n_checks++;
                if (c != 29 || obs_vec[15:0] !== sw) begin
                    n_fail++; $display("[TB] FAIL bounce_valid: at c=%0d data=%h expected c=29 data=%h", c, obs_vec[15:0], sw);
                end
            end
        end
        n_checks++;
        if (nvalid != 1) begin
            n_fail++; $display("[TB] FAIL bounce_count: got %0d pulses expected 1", nvalid);
        end
        idle_cycles(8);
    endtask

    task automatic test_held();
        logic [15:0] x1 = 16'($urandom);
        logic [15:0] x2 = ~x1;
        int nvalid = 0;
        for (int c = 0; c < 35; c++) begin
            drive_cycle(0, c >= 8 && c <= 33, (c < 18) || (c >= 26), (c < 18) ? x1 : x2);
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_fail++; $display("[TB] FAIL held_model c=%0d: got %h expected %h", c, obs_vec, exp_vec);
            end
            if (c == 12) begin
                n_checks++;
                if (obs_vec[17] !== 1'b1) begin
                    n_fail++; $display("[TB] FAIL held_waiting: got %b expected 1", obs_vec[17]);
                end
            end
            if (obs_vec[18]) begin
                nvalid++;
                n_checks++;
                if (c != 33 || obs_vec[15:0] !== x2) begin
                    n_fail++; $display("[TB] FAIL held_valid: at c=%0d data=%h expected c=33 data=%h", c, obs_vec[15:0], x2);
                end
            end
        end
        n_checks++;
        if (nvalid != 1) begin
            n_fail++; $display("[TB] FAIL held_count: got %0d pulses expected 1", nvalid);
        end
        idle_cycles(8);
    endtask

    task automatic test_abort_reset();
        logic [15:0] keep = m_data;
        logic [15:0] sw = 16'($urandom);
        bit seen = 0;
        // press event lands in the same cycle the request falls
        for (int c = 0; c < 11; c++) begin
            drive_cycle(0, c <= 6, c >= 1, ~keep);
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_fail++; $display("[TB] FAIL abort_model c=%0d: got %h expected %h", c, obs_vec, exp_vec);
            end
            if (c >= 8) begin
                n_checks++;
                if (obs_vec[18:17] !== 2'b00 || obs_vec[15:0] !== keep) begin
                    n_fail++; $display("[TB] FAIL abort_idle c=%0d: valid,wait=%b data=%h expected 00 %h", c, obs_vec[18:17], obs_vec[15:0], keep);
                end
            end
        end
        idle_cycles(8);
        // reset in the middle of a wait with the request still high
        for (int c = 0; c < 17; c++) begin
            drive_cycle(c == 5, c <= 15, c >= 8, sw);
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_fail++; $display("[TB] FAIL rstwait_model c=%0d: got %h expected %h", c, obs_vec, exp_vec);
            end
            if (c == 6) begin
                n_checks++;
                if (obs_vec !== 20'h80000) begin
                    n_fail++; $display("[TB] FAIL rstwait_values: got %h expected %h", obs_vec, 20'h80000);
                end
            end
            if (c == 7) begin
                n_checks++;
                if (obs_vec[17] !== 1'b1) begin
                    n_fail++; $display("[TB] FAIL rstwait_restart: waiting=%b expected 1", obs_vec[17]);
                end
            end
            if (c == 15) begin
                seen = obs_vec[18];
                n_checks++;
                if (obs_vec[18] !== 1'b1 || obs_vec[15:0] !== sw) begin
                    n_fail++; $display("[TB] FAIL rstwait_done: valid=%b data=%h expected 1 %h", obs_vec[18], obs_vec[15:0], sw);
                end
            end
        end
        if (!seen) $display("[TB] no completion after reset restart");
        idle_cycles(8);
    endtask

    task automatic test_back_to_back();
        int nvalid = 0;
        int nfree  = 0;
        for (int c = 0; c < 32; c++) begin
            drive_cycle(0, c <= 28, (c >= 2 && c <= 9) || (c >= 20 && c <= 27), (c < 15) ? 16'h0001 : 16'h0002);
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_fail++; $display("[TB] FAIL b2b_model c=%0d: got %h expected %h", c, obs_vec, exp_vec);
            end
            if (c <= 28 && !obs_vec[19]) nfree++;
            if (obs_vec[18]) begin
                nvalid++;
                n_checks++;
                if ((nvalid == 1 && (c != 9 || obs_vec[15:0] !== 16'h0001)) ||
                    (nvalid == 2 && (c != 27 || obs_vec[15:0] !== 16'h0002))) begin
                    n_fail++; $display("[TB] FAIL b2b_valid%0d: at c=%0d data=%h", nvalid, c, obs_vec[15:0]);
                end
            end
        end
        n_checks++;
        if (nvalid != 2 || nfree < 2) begin
            n_fail++; $display("[TB] FAIL b2b_count: pulses=%0d free=%0d expected 2 and >=2", nvalid, nfree);
        end
        idle_cycles(8);
    endtask

    task automatic test_timeout();
`ifdef IO_TIMEOUT_EN
        for (int c = 0; c < 59; c++) begin
            drive_cycle(0, (c <= 51) || (c >= 56 && c <= 57), 0, 16'hFFFF);
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_fail++; $display("[TB] FAIL tmo_model c=%0d: got %h expected %h", c, obs_vec, exp_vec);
            end
            if (c == 50 || c == 51) begin
                n_checks++;
                if (obs_vec[18] !== (c == 51) || (c == 51 && obs_vec[16:0] !== 17'h10000)) begin
                    n_fail++; $display("[TB] FAIL tmo_done c=%0d: valid=%b flag=%b data=%h", c, obs_vec[18], obs_vec[16], obs_vec[15:0]);
                end
            end
            if (c == 54 || c == 56 || c == 57) begin
                n_checks++;
                if (obs_vec[16] !== (c != 57)) begin
                    n_fail++; $display("[TB] FAIL tmo_flag c=%0d: got %b expected %b", c, obs_vec[16], c != 57);
                end
            end
        end
`else
        for (int c = 0; c < 62; c++) begin
            drive_cycle(0, c <= 59, 0, 16'hFFFF);
            n_checks++;
            if (obs_vec !== exp_vec || obs_vec[18] !== 1'b0 || obs_vec[16] !== 1'b0) begin
                n_fail++; $display("[TB] FAIL nowait_limit c=%0d: got %h expected %h", c, obs_vec, exp_vec);
            end
        end
`endif
        idle_cycles(4);
    endtask

    task automatic test_random();
        bit req = 0;
        bit btn = 0;
        bit rst;
        logic [15:0] sw = 16'($urandom);
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 9) == 0) req = ~req;
            if ($urandom_range(0, 4) == 0) btn = ~btn;
            if ($urandom_range(0, 7) == 0) sw = 16'($urandom);
            rst = ($urandom_range(0, 99) == 0);
            drive_cycle(rst, req, btn, sw);
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_fail++; $display("[TB] FAIL random_model c=%0d: got %h expected %h", c, obs_vec, exp_vec);
            end
        end
    endtask

    initial begin
        reset = 1'b1; ior_req = 1'b0; button_confirm = 1'b0; switch_in = '0;
        model_edge(1, 0, 0, 16'h0);
        @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_bounce();
        test_held();
        test_abort_reset();
        test_back_to_back();
        test_timeout();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
